// File: rtl/pe_pkg.sv
// Shared definitions for the 1-D convolution PE: FSM state encoding and the
// default accumulator width.
package pe_pkg;

  typedef logic [1:0] pe_state_t;

  localparam pe_state_t S_IDLE = 2'd0;
  localparam pe_state_t S_LOAD = 2'd1;
  localparam pe_state_t S_RUN  = 2'd2;

  // Wide enough for K full-scale products plus one psum without loss.
  function automatic int pe_aw(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/pe_window.sv
// Sliding input window for conv1d_pe: shift register of past samples, fill
// counter and row clear. Presents the post-shift window combinationally.
module pe_window #(
  parameter int DW = 8,
  parameter int K  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 shift,
  input  logic                 clr,
  input  logic [DW-1:0]        din,
  output logic [K-1:0][DW-1:0] win_nxt,
  output logic                 full_nxt
);

  localparam int FW = $clog2(K + 1);

  // The oldest tap only ever falls off the end, so K-1 older samples are
  // held and the incoming sample completes the window as win_nxt[0].
  logic [K-2:0][DW-1:0] hist;
  logic [FW-1:0]        fill;

  assign win_nxt  = {hist, din};
  assign full_nxt = (fill >= FW'(K - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= win_nxt[K-2:0];
      fill <= full_nxt ? FW'(K) : fill + 1'b1;
    end
  end

endmodule

// File: rtl/conv1d_pe.sv
// Parametrised 1-D convolution PE: K-tap weight load, sliding window and a
// registered dot product (plus optional psum) per accepted sample.
module conv1d_pe
  import pe_pkg::*;
#(
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int AW     = pe_aw(DW, K),
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          acc_en,
  input  logic [AW-1:0] psum_in,
  output logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_data,
  output logic          o_last,
  input  logic          o_ready,
  output logic          short_row
);

  localparam int CW = $clog2(K);
  localparam int MW = (AW > 2 * DW + 2) ? AW : 2 * DW + 2;

  pe_state_t            state;
  logic [CW-1:0]        wcnt;
  logic [K-1:0][DW-1:0] w;
  logic                 weights_ok;

  logic                 i_acc;
  logic [K-1:0][DW-1:0] win_nxt;
  logic                 full_nxt;
  logic [K-1:0][AW-1:0] prod;
  logic [AW-1:0]        y;

  assign w_ready = (state == S_IDLE) || (state == S_LOAD);
  assign i_ready = weights_ok
                && ((state == S_IDLE) ? !w_valid : (state == S_RUN))
                && (!o_valid || o_ready);
  assign i_acc   = i_valid && i_ready;

  pe_window #(.DW(DW), .K(K)) u_win (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift    (i_acc),
    .clr      (i_acc && i_last),
    .din      (i_data),
    .win_nxt  (win_nxt),
    .full_nxt (full_nxt)
  );

  // Operands extended to MW before multiplying: the low MW bits of the
  // product are then correct two's complement for either signedness.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [MW-1:0] ea, eb;
    ea = {{(MW - DW){(SIGNED != 0) && a[DW-1]}}, a};
    eb = {{(MW - DW){(SIGNED != 0) && b[DW-1]}}, b};
    return AW'(ea * eb);
  endfunction

  for (genvar g = 0; g < K; g++) begin : g_mul
    assign prod[g] = mul_ext(w[g], win_nxt[g]);
  end

  always_comb begin
    y = acc_en ? psum_in : '0;
    for (int j = 0; j < K; j++) y = y + prod[j];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      w          <= '0;
      weights_ok <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_valid) begin
            w[0]       <= w_data;
            wcnt       <= CW'(1);
            weights_ok <= 1'b0;
            state      <= S_LOAD;
          end else if (i_acc && !i_last) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (w_valid) begin
            w[wcnt] <= w_data;
            if (wcnt == CW'(K - 1)) begin
              wcnt       <= '0;
              weights_ok <= 1'b1;
              state      <= S_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_acc && i_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new accept overwrites the output register directly when the old
  // result is being consumed in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
      short_row <= 1'b0;
    end else begin
      if (i_acc && full_nxt) begin
        o_valid <= 1'b1;
        o_data  <= y;
        o_last  <= i_last;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
      short_row <= i_acc && i_last && !full_nxt;
    end
  end

endmodule

// File: tb/tb_conv1d_pe.sv
// Directed bench for conv1d_pe: three instances (unsigned default AW, signed,
// unsigned AW=16) share one stimulus stream; expected values are hand-derived.
module tb_conv1d_pe;

  localparam int DW  = 8;
  localparam int K   = 3;
  localparam int AWU = 2 * DW + $clog2(K) + 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           w_valid = 1'b0;
  logic [DW-1:0]  w_data = '0;
  logic           i_valid = 1'b0;
  logic [DW-1:0]  i_data = '0;
  logic           i_last = 1'b0;
  logic           acc_en = 1'b0;
  logic [AWU-1:0] psum = '0;
  logic           o_ready = 1'b1;

  logic           u_w_ready, u_i_ready, u_o_valid, u_o_last, u_short_row;
  logic [AWU-1:0] u_o_data;
  logic           s_w_ready, s_i_ready, s_o_valid, s_o_last, s_short_row;
  logic [AWU-1:0] s_o_data;
  logic           n_w_ready, n_i_ready, n_o_valid, n_o_last, n_short_row;
  logic [15:0]    n_o_data;

  int checks = 0;
  int errors = 0;
  int sr_cnt = 0;
  logic [AWU-1:0] qu[$];
  logic [AWU-1:0] qs[$];
  logic [15:0]    qn[$];
  bit             qul[$];

  always #5 clk = ~clk;

  conv1d_pe #(.DW(DW), .K(K), .SIGNED(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_data(w_data),
    .w_ready(u_w_ready), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .acc_en(acc_en), .psum_in(psum), .i_ready(u_i_ready), .o_valid(u_o_valid),
    .o_data(u_o_data), .o_last(u_o_last), .o_ready(o_ready), .short_row(u_short_row)
  );

  conv1d_pe #(.DW(DW), .K(K), .SIGNED(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_data(w_data),
    .w_ready(s_w_ready), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .acc_en(acc_en), .psum_in(psum), .i_ready(s_i_ready), .o_valid(s_o_valid),
    .o_data(s_o_data), .o_last(s_o_last), .o_ready(o_ready), .short_row(s_short_row)
  );

  conv1d_pe #(.DW(DW), .K(K), .AW(16), .SIGNED(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_data(w_data),
    .w_ready(n_w_ready), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .acc_en(acc_en), .psum_in(psum[15:0]), .i_ready(n_i_ready), .o_valid(n_o_valid),
    .o_data(n_o_data), .o_last(n_o_last), .o_ready(o_ready), .short_row(n_short_row)
  );

  // Collect consumed results mid-cycle, well clear of both clock edges.
  always @(negedge clk) begin
    #2;
    if (u_o_valid && o_ready) begin qu.push_back(u_o_data); qul.push_back(u_o_last); end
    if (s_o_valid && o_ready) qs.push_back(s_o_data);
    if (n_o_valid && o_ready) qn.push_back(n_o_data);
    if (u_short_row) sr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    qu.delete(); qs.delete(); qn.delete(); qul.delete();
  endtask

  task automatic put_w(input logic [DW-1:0] d);
    @(negedge clk); w_valid = 1'b1; w_data = d; #1;
    for (int n = 0; n < 50 && u_w_ready !== 1'b1; n++) begin @(negedge clk); #1; end
    checks++;
    if (u_w_ready !== 1'b1) begin errors++; $display("FAIL w_handshake got w_ready=%0b want 1", u_w_ready); end
    @(posedge clk);
  endtask

  task automatic load3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    put_w(a); put_w(b); put_w(c);
    @(negedge clk); w_valid = 1'b0;
  endtask

  task automatic put_i(input logic [DW-1:0] d, input bit last);
    @(negedge clk); i_valid = 1'b1; i_data = d; i_last = last; #1;
    for (int n = 0; n < 50 && u_i_ready !== 1'b1; n++) begin @(negedge clk); #1; end
    checks++;
    if (u_i_ready !== 1'b1) begin errors++; $display("FAIL i_handshake got i_ready=%0b want 1", u_i_ready); end
    @(posedge clk);
  endtask

  task automatic end_row();
    @(negedge clk); i_valid = 1'b0; i_last = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    i_valid = 1'b1; #3;
    checks++; if (u_o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got %0b want 0", u_o_valid); end
    checks++; if (u_o_data !== '0) begin errors++; $display("FAIL rst_o_data got %0d want 0", u_o_data); end
    checks++; if (u_o_last !== 1'b0) begin errors++; $display("FAIL rst_o_last got %0b want 0", u_o_last); end
    checks++; if (u_short_row !== 1'b0) begin errors++; $display("FAIL rst_short_row got %0b want 0", u_short_row); end
    checks++; if (u_w_ready !== 1'b1) begin errors++; $display("FAIL rst_w_ready got %0b want 1", u_w_ready); end
    checks++; if (u_i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %0b want 0", u_i_ready); end
    i_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_q();
    load3(8'd1, 8'd2, 8'd3);
    put_i(8'd1, 0); put_i(8'd2, 0); put_i(8'd3, 0); put_i(8'd4, 1);
    end_row();
    checks++;
    if (qu.size() != 2) begin errors++; $display("FAIL basic_count got %0d want 2", qu.size()); end
    else begin
      checks++; if (qu[0] !== 10) begin errors++; $display("FAIL basic_y0 got %0d want 10", qu[0]); end
      checks++; if (qul[0] !== 1'b0) begin errors++; $display("FAIL basic_last0 got %0b want 0", qul[0]); end
      checks++; if (qu[1] !== 16) begin errors++; $display("FAIL basic_y1 got %0d want 16", qu[1]); end
      checks++; if (qul[1] !== 1'b1) begin errors++; $display("FAIL basic_last1 got %0b want 1", qul[1]); end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    put_i(8'd1, 0); put_i(8'd2, 0); put_i(8'd3, 0);
    @(negedge clk); o_ready = 1'b0; i_valid = 1'b1; i_data = 8'd4; i_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (u_o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %0b want 1", c, u_o_valid); end
      checks++; if (u_o_data !== 10) begin errors++; $display("FAIL bp_hold c%0d got %0d want 10", c, u_o_data); end
      checks++; if (u_i_ready !== 1'b0) begin errors++; $display("FAIL bp_i_ready c%0d got %0b want 0", c, u_i_ready); end
      @(negedge clk);
    end
    o_ready = 1'b1; #1;
    checks++; if (u_i_ready !== 1'b1) begin errors++; $display("FAIL bp_release got i_ready=%0b want 1", u_i_ready); end
    @(posedge clk);
    end_row();
    checks++;
    if (qu.size() != 2) begin errors++; $display("FAIL bp_count got %0d want 2", qu.size()); end
    else begin
      checks++; if (qu[0] !== 10 || qu[1] !== 16) begin errors++; $display("FAIL bp_seq got %0d,%0d want 10,16", qu[0], qu[1]); end
    end
  endtask

  task automatic test_short_row();
    int sr0;
    clear_q();
    sr0 = sr_cnt;
    put_i(8'd5, 0); put_i(8'd6, 1);
    @(negedge clk); i_valid = 1'b0; i_last = 1'b0; #1;
    checks++; if (u_short_row !== 1'b1) begin errors++; $display("FAIL short_pulse got %0b want 1", u_short_row); end
    @(negedge clk); #1;
    checks++; if (u_short_row !== 1'b0) begin errors++; $display("FAIL short_pulse_end got %0b want 0", u_short_row); end
    repeat (2) @(negedge clk);
    checks++; if (qu.size() != 0) begin errors++; $display("FAIL short_no_result got %0d results want 0", qu.size()); end
    checks++; if (sr_cnt - sr0 != 1) begin errors++; $display("FAIL short_count got %0d pulses want 1", sr_cnt - sr0); end
    put_i(8'd1, 0); put_i(8'd1, 0); put_i(8'd1, 1);
    end_row();
    checks++;
    if (qu.size() != 1) begin errors++; $display("FAIL retain_count got %0d want 1", qu.size()); end
    else begin
      checks++; if (qu[0] !== 6) begin errors++; $display("FAIL retain_y got %0d want 6", qu[0]); end
    end
  endtask

  task automatic test_signed_psum();
    clear_q();
    load3(8'hFF, 8'h00, 8'h00);
    acc_en = 1'b1; psum = AWU'(100);
    put_i(8'd3, 0); put_i(8'd4, 0); put_i(8'd7, 1);
    end_row();
    acc_en = 1'b0; psum = '0;
    checks++;
    if (qs.size() != 1) begin errors++; $display("FAIL signed_count got %0d want 1", qs.size()); end
    else begin
      checks++; if (qs[0] !== 93) begin errors++; $display("FAIL signed_y got %0d want 93", qs[0]); end
    end
    checks++;
    if (qu.size() != 1) begin errors++; $display("FAIL unsigned_psum_count got %0d want 1", qu.size()); end
    else begin
      checks++; if (qu[0] !== 1885) begin errors++; $display("FAIL unsigned_psum_y got %0d want 1885", qu[0]); end
    end
  endtask

  task automatic test_wrap();
    clear_q();
    load3(8'd255, 8'd255, 8'd255);
    put_i(8'd255, 0); put_i(8'd255, 0); put_i(8'd255, 1);
    end_row();
    checks++;
    if (qu.size() != 1 || qn.size() != 1 || qs.size() != 1) begin
      errors++; $display("FAIL wrap_count got %0d/%0d/%0d want 1/1/1", qu.size(), qn.size(), qs.size());
    end else begin
      checks++; if (qu[0] !== 195075) begin errors++; $display("FAIL wrap_wide got %0d want 195075", qu[0]); end
      checks++; if (qn[0] !== 16'd64003) begin errors++; $display("FAIL wrap_aw16 got %0d want 64003", qn[0]); end
      checks++; if (qs[0] !== 3) begin errors++; $display("FAIL wrap_signed got %0d want 3", qs[0]); end
    end
  endtask

  task automatic test_priority();
    clear_q();
    @(negedge clk); w_valid = 1'b1; w_data = 8'd2; i_valid = 1'b1; i_data = 8'd9; i_last = 1'b0; #1;
    checks++; if (u_w_ready !== 1'b1) begin errors++; $display("FAIL prio_w_ready got %0b want 1", u_w_ready); end
    checks++; if (u_i_ready !== 1'b0) begin errors++; $display("FAIL prio_i_ready got %0b want 0", u_i_ready); end
    @(posedge clk);
    @(negedge clk); w_data = 8'd0; #1;
    checks++; if (u_i_ready !== 1'b0) begin errors++; $display("FAIL load_i_ready got %0b want 0", u_i_ready); end
    @(posedge clk);
    @(negedge clk); w_data = 8'd0;
    @(posedge clk);
    @(negedge clk); w_valid = 1'b0; #1;
    checks++; if (u_i_ready !== 1'b1) begin errors++; $display("FAIL post_load_i_ready got %0b want 1", u_i_ready); end
    @(posedge clk);
    put_i(8'd5, 0); put_i(8'd4, 1);
    end_row();
    checks++;
    if (qu.size() != 1) begin errors++; $display("FAIL prio_count got %0d want 1", qu.size()); end
    else begin
      checks++; if (qu[0] !== 8) begin errors++; $display("FAIL prio_y got %0d want 8", qu[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    put_w(8'd1); put_w(8'd2);
    @(negedge clk); w_valid = 1'b0; reset_n = 1'b0; #1;
    checks++; if (u_w_ready !== 1'b1) begin errors++; $display("FAIL rload_w_ready got %0b want 1", u_w_ready); end
    #1 reset_n = 1'b1;
    i_valid = 1'b1; i_data = 8'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (u_i_ready !== 1'b0) begin errors++; $display("FAIL rload_i_ready c%0d got %0b want 0", c, u_i_ready); end
    end
    i_valid = 1'b0;
    load3(8'd1, 8'd2, 8'd3);
    @(negedge clk); i_valid = 1'b1; #1;
    checks++; if (u_i_ready !== 1'b1) begin errors++; $display("FAIL reload_i_ready got %0b want 1", u_i_ready); end
    #1 i_valid = 1'b0;
    put_i(8'd1, 0); put_i(8'd2, 0); put_i(8'd3, 0);
    @(negedge clk); i_valid = 1'b0; o_ready = 1'b0; #1;
    checks++; if (u_o_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got o_valid=%0b want 1", u_o_valid); end
    #1 reset_n = 1'b0; #1;
    checks++; if (u_o_valid !== 1'b0) begin errors++; $display("FAIL rmid_o_valid got %0b want 0", u_o_valid); end
    checks++; if (u_o_data !== '0) begin errors++; $display("FAIL rmid_o_data got %0d want 0", u_o_data); end
    #1 reset_n = 1'b1; o_ready = 1'b1;
    clear_q();
    load3(8'd1, 8'd1, 8'd1);
    put_i(8'd2, 0); put_i(8'd3, 0); put_i(8'd4, 1);
    end_row();
    checks++;
    if (qu.size() != 1) begin errors++; $display("FAIL rmid_count got %0d want 1", qu.size()); end
    else begin
      checks++; if (qu[0] !== 9) begin errors++; $display("FAIL rmid_y got %0d want 9", qu[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_row();
    test_signed_psum();
    test_wrap();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
